// File: rtl/map_mem_responder.sv
// Memory-side responder for the SOFM map-weight port: turns level read/write
// strobes into single-port SRAM accesses and streams the whole map out on done.
module map_mem_responder #(
    parameter int DEPTH = 88594,
    parameter int AW    = 20,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_out,
    output logic [DW-1:0] data_in,
    output logic          stall,
    input  logic          done,
    output logic          sram_en,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          dump_done,
    output logic [31:0]   n_writeback,
    output logic          err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_DUMP_RD  = 3'd2;
    localparam logic [2:0] S_DUMP_OUT = 3'd3;
    localparam logic [2:0] S_FIN      = 3'd4;

    localparam logic [31:0]   DEPTH_U   = 32'(DEPTH);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          rd_oor_q, rd_oor_d;
    logic [AW-1:0] dump_cnt_q, dump_cnt_d;
    logic [DW-1:0] dump_data_q, dump_data_d;
    logic          dump_first_q, dump_first_d;
    logic          dump_valid_q, dump_valid_d;
    logic          dump_done_q, dump_done_d;
    logic [31:0]   nwb_q, nwb_d;
    logic          err_q, err_d;

    logic          addr_ok;
    logic [DW-1:0] rd_word;

    assign addr_ok = {{(32 - AW){1'b0}}, addr} < DEPTH_U;
    assign rd_word = rd_oor_q ? '0 : sram_rdata;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rd_oor_d     = rd_oor_q;
        dump_cnt_d   = dump_cnt_q;
        dump_data_d  = dump_data_q;
        dump_first_d = 1'b0;
        dump_valid_d = 1'b0;
        dump_done_d  = dump_done_q;
        nwb_d        = nwb_q;
        err_d        = err_q;
        sram_en      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        stall        = 1'b0;
        data_in      = hold_q;

        case (state_q)
            S_IDLE: begin
                stall = read;
                if (done) begin
                    dump_cnt_d = '0;
                    state_d    = S_DUMP_RD;
                end else if (read) begin
                    // Out-of-range reads still take the RD slot and return zero.
                    state_d  = S_RD;
                    rd_oor_d = !addr_ok;
                    if (addr_ok) begin
                        sram_en   = 1'b1;
                        sram_addr = addr;
                    end
                    if (write || !addr_ok) begin
                        err_d = 1'b1;
                    end
                end else if (write) begin
                    if (addr_ok) begin
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = addr;
                        sram_wdata = data_out;
                        nwb_d      = nwb_q + 32'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                data_in = rd_word;
                hold_d  = rd_word;
                state_d = S_IDLE;
            end
            S_DUMP_RD: begin
                stall        = 1'b1;
                sram_en      = 1'b1;
                sram_addr    = dump_cnt_q;
                dump_valid_d = 1'b1;
                dump_first_d = 1'b1;
                state_d      = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                stall = 1'b1;
                if (dump_first_q) begin
                    dump_data_d = sram_rdata;
                end
                if (dump_ready) begin
                    if (dump_cnt_q == LAST_WORD) begin
                        dump_done_d = 1'b1;
                        state_d     = S_FIN;
                    end else begin
                        dump_cnt_d = dump_cnt_q + 1'b1;
                        state_d    = S_DUMP_RD;
                    end
                end else begin
                    dump_valid_d = 1'b1;
                end
            end
            S_FIN: begin
                stall = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset cycle must never leave a half-issued write behind.
        if (rst) begin
            sram_en = 1'b0;
            sram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            rd_oor_q     <= 1'b0;
            dump_cnt_q   <= '0;
            dump_data_q  <= '0;
            dump_first_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            nwb_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            rd_oor_q     <= rd_oor_d;
            dump_cnt_q   <= dump_cnt_d;
            dump_data_q  <= dump_data_d;
            dump_first_q <= dump_first_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
            nwb_q        <= nwb_d;
            err_q        <= err_d;
        end
    end

    // The SRAM word lands in the first DUMP_OUT cycle; later cycles replay the capture.
    assign dump_data   = dump_first_q ? sram_rdata : dump_data_q;
    assign dump_addr   = dump_cnt_q;
    assign dump_valid  = dump_valid_q;
    assign dump_done   = dump_done_q;
    assign n_writeback = nwb_q;
    assign err         = err_q;

endmodule

// File: tb/tb_map_mem_responder.sv
// Bench for map_mem_responder: a full-depth instance for the initiator port and
// a 4-word instance for the dump stream, each with its own SRAM model.
module tb_map_mem_responder;

    localparam int DEPTH  = 88594;
    localparam int SDEPTH = 4;
    localparam int AW     = 20;
    localparam int DW     = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // full-depth instance
    logic          rst = 1'b1, read = 1'b0, write = 1'b0, done = 1'b0, dump_ready = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_out = '0;
    logic [DW-1:0] data_in, sram_wdata, dump_data;
    logic [DW-1:0] sram_rdata = '0;
    logic          stall, sram_en, sram_we, dump_valid, dump_done, err;
    logic [AW-1:0] sram_addr, dump_addr;
    logic [31:0]   n_writeback;

    // 4-word instance
    logic          s_rst = 1'b1, s_read = 1'b0, s_write = 1'b0, s_done = 1'b0, s_dump_ready = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data_out = '0;
    logic [DW-1:0] s_data_in, s_sram_wdata, s_dump_data;
    logic [DW-1:0] s_sram_rdata = '0;
    logic          s_stall, s_sram_en, s_sram_we, s_dump_valid, s_dump_done, s_err;
    logic [AW-1:0] s_sram_addr, s_dump_addr;
    logic [31:0]   s_n_writeback;

    map_mem_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .data_out(data_out), .data_in(data_in), .stall(stall), .done(done),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done), .n_writeback(n_writeback), .err(err)
    );

    map_mem_responder #(.DEPTH(SDEPTH), .AW(AW), .DW(DW)) u_small (
        .clk(clk), .rst(s_rst), .read(s_read), .write(s_write), .addr(s_addr),
        .data_out(s_data_out), .data_in(s_data_in), .stall(s_stall), .done(s_done),
        .sram_en(s_sram_en), .sram_we(s_sram_we), .sram_addr(s_sram_addr),
        .sram_wdata(s_sram_wdata), .sram_rdata(s_sram_rdata),
        .dump_valid(s_dump_valid), .dump_ready(s_dump_ready), .dump_addr(s_dump_addr),
        .dump_data(s_dump_data), .dump_done(s_dump_done), .n_writeback(s_n_writeback), .err(s_err)
    );

    // SRAM models: synchronous single port, one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s_mem [SDEPTH];
    always @(posedge clk) begin
        if (sram_en) begin
            en_cnt <= en_cnt + 1;
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
        if (s_sram_en) begin
            if (s_sram_we) s_mem[s_sram_addr[1:0]] <= s_sram_wdata;
            else           s_sram_rdata            <= s_mem[s_sram_addr[1:0]];
        end
    end

    // reference model: expected map contents and writeback count
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] s_ref [SDEPTH];
    int            exp_nwb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int a, output logic [DW-1:0] d, output logic st0, output logic st1);
        read = 1'b1; write = 1'b0; addr = AW'(a);
        @(negedge clk) st0 = stall;
        tick();
        @(negedge clk) begin st1 = stall; d = data_in; end
        tick();
        read = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, output logic st, output logic wr);
        write = 1'b1; read = 1'b0; addr = AW'(a); data_out = d;
        @(negedge clk) begin st = stall; wr = sram_en & sram_we; end
        tick();
        write = 1'b0;
    endtask

    task automatic s_do_read(input int a, output logic [DW-1:0] d, output logic st0, output logic st1);
        s_read = 1'b1; s_write = 1'b0; s_addr = AW'(a);
        @(negedge clk) st0 = s_stall;
        tick();
        @(negedge clk) begin st1 = s_stall; d = s_data_in; end
        tick();
        s_read = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1; tick(); rst = 1'b0;
        exp_nwb = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; s_rst = 1'b0;
        exp_nwb = 0;
        @(negedge clk);
        checks++;
        if ({stall, sram_en, sram_we, dump_valid, dump_done, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {stall, sram_en, sram_we, dump_valid, dump_done, err});
        end
        checks++;
        if ({data_in, dump_data, sram_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", data_in, dump_data, sram_wdata);
        end
        checks++;
        if (sram_addr !== '0 || dump_addr !== '0 || n_writeback !== 32'd0) begin
            failures++;
            $display("FAIL reset_counts got=%h/%h/%0d exp=0", sram_addr, dump_addr, n_writeback);
        end
        checks++;
        if ({s_stall, s_dump_valid, s_dump_done, s_err} !== 4'b0 || s_dump_data !== '0) begin
            failures++;
            $display("FAIL reset_small got=%b data=%h exp=0", {s_stall, s_dump_valid, s_dump_done, s_err}, s_dump_data);
        end
        $display("reset: checked reset values");
        tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        logic st0, st1, wr;
        do_write(5, 64'h0123456789ABCDEF, st0, wr);
        ref_mem[5] = 64'h0123456789ABCDEF;
        exp_nwb++;
        checks++;
        if (st0 !== 1'b0 || wr !== 1'b1) begin
            failures++;
            $display("FAIL write_cycle got stall=%b wr=%b exp stall=0 wr=1", st0, wr);
        end
        do_read(5, d, st0, st1);
        checks++;
        if (st0 !== 1'b1 || st1 !== 1'b0 || d !== ref_mem[5]) begin
            failures++;
            $display("FAIL read_after_write got stall=%b%b data=%h exp stall=10 data=%h", st0, st1, d, ref_mem[5]);
        end
        @(negedge clk);
        checks++;
        if (data_in !== ref_mem[5] || n_writeback !== 32'(exp_nwb)) begin
            failures++;
            $display("FAIL read_hold got data=%h nwb=%0d exp data=%h nwb=%0d", data_in, n_writeback, ref_mem[5], exp_nwb);
        end
        $display("write_read: addr 5 data=%h nwb=%0d", d, n_writeback);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic st0, st1;
        int c0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            do_read(i, d, st0, st1);
            checks++;
            if (st0 !== 1'b1 || st1 !== 1'b0 || d !== ref_mem[i]) begin
                failures++;
                $display("FAIL b2b_read%0d got stall=%b%b data=%h exp stall=10 data=%h", i, st0, st1, d, ref_mem[i]);
            end
            $display("b2b: read addr %0d data=%h", i, d);
        end
        checks++;
        if (cyc - c0 != 8) begin
            failures++;
            $display("FAIL b2b_cycles got=%0d exp=8", cyc - c0);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d, exp_d;
        logic st0, st1, wr;
        int a;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin
                d = {$urandom, $urandom};
                do_write(a, d, st0, wr);
                ref_mem[a] = d;
                exp_nwb++;
                checks++;
                if (st0 !== 1'b0 || wr !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_write addr=%0d got stall=%b wr=%b exp stall=0 wr=1", a, st0, wr);
                end
                $display("rand: write addr %0d data=%h", a, d);
            end else begin
                exp_d = ref_mem[a];
                do_read(a, d, st0, st1);
                checks++;
                if (st0 !== 1'b1 || st1 !== 1'b0 || d !== exp_d) begin
                    failures++;
                    $display("FAIL rand_read addr=%0d got data=%h stall=%b%b exp data=%h stall=10", a, d, st0, st1, exp_d);
                end
                $display("rand: read addr %0d data=%h", a, d);
            end
        end
        checks++;
        if (n_writeback !== 32'(exp_nwb) || err !== 1'b0) begin
            failures++;
            $display("FAIL rand_totals got nwb=%0d err=%b exp nwb=%0d err=0", n_writeback, err, exp_nwb);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d;
        logic st0, st1, wr;
        pulse_rst();
        en_cnt = 0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL oor_err_clear got=%b exp=0", err);
        end
        do_read(DEPTH, d, st0, st1);
        checks++;
        if (d !== '0 || st0 !== 1'b1 || st1 !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL oor_read got data=%h stall=%b%b err=%b exp data=0 stall=10 err=1", d, st0, st1, err);
        end
        do_write(100000, 64'hDEADBEEFCAFEF00D, st0, wr);
        repeat (3) tick();
        checks++;
        if (n_writeback !== 32'd0 || err !== 1'b1 || en_cnt != 0 || wr !== 1'b0) begin
            failures++;
            $display("FAIL oor_write got nwb=%0d err=%b en=%0d exp nwb=0 err=1 en=0", n_writeback, err, en_cnt);
        end
        $display("oor: read %0d data=%h, write 100000 dropped, err=%b", DEPTH, d, err);
    endtask

    task automatic test_read_write_both();
        logic [DW-1:0] d;
        logic st0, st1, we0;
        pulse_rst();
        read = 1'b1; write = 1'b1; addr = AW'(7); data_out = ~ref_mem[7];
        @(negedge clk) begin st0 = stall; we0 = sram_we; end
        tick();
        @(negedge clk) d = data_in;
        tick();
        read = 1'b0; write = 1'b0;
        checks++;
        if (st0 !== 1'b1 || we0 !== 1'b0 || d !== ref_mem[7]) begin
            failures++;
            $display("FAIL rw_both got stall=%b we=%b data=%h exp stall=1 we=0 data=%h", st0, we0, d, ref_mem[7]);
        end
        do_read(7, d, st0, st1);
        checks++;
        if (d !== ref_mem[7] || err !== 1'b1 || n_writeback !== 32'd0) begin
            failures++;
            $display("FAIL rw_both_after got data=%h err=%b nwb=%0d exp data=%h err=1 nwb=0", d, err, n_writeback, ref_mem[7]);
        end
        $display("rw_both: addr 7 data=%h err=%b", d, err);
    endtask

    task automatic test_dump();
        int idx, fin_cyc, stall_left;
        s_rst = 1'b1; tick(); s_rst = 1'b0;
        for (int i = 0; i < SDEPTH; i++) begin
            s_ref[i] = {$urandom, $urandom};
            s_write = 1'b1; s_addr = AW'(i); s_data_out = s_ref[i];
            tick();
        end
        s_write = 1'b0;
        s_done = 1'b1; tick(); s_done = 1'b0;
        idx = 0; fin_cyc = 0; stall_left = 3;
        for (int k = 1; k <= 40; k++) begin
            s_dump_ready = !(s_dump_valid && s_dump_addr == AW'(1) && stall_left > 0);
            @(negedge clk);
            if (s_dump_done) begin
                fin_cyc = k;
                break;
            end
            if (s_dump_valid) begin
                checks++;
                if (idx >= SDEPTH || s_dump_addr !== AW'(idx) || s_dump_data !== s_ref[idx % SDEPTH] || s_stall !== 1'b1) begin
                    failures++;
                    $display("FAIL dump_word got addr=%0d data=%h exp addr=%0d data=%h", s_dump_addr, s_dump_data, idx, s_ref[idx % SDEPTH]);
                end
                $display("dump: addr %0d data=%h ready=%b", s_dump_addr, s_dump_data, s_dump_ready);
                if (s_dump_ready) idx++;
                else stall_left--;
            end
            tick();
        end
        checks++;
        if (fin_cyc != 2 * SDEPTH + 4 || idx != SDEPTH || s_dump_valid !== 1'b0 || s_stall !== 1'b1) begin
            failures++;
            $display("FAIL dump_finish got cycle=%0d words=%0d valid=%b exp cycle=%0d words=%0d valid=0", fin_cyc, idx, s_dump_valid, 2 * SDEPTH + 4, SDEPTH);
        end
        tick();
        s_write = 1'b1; s_addr = '0; s_data_out = '1;
        @(negedge clk);
        checks++;
        if (s_sram_en !== 1'b0 || s_stall !== 1'b1) begin
            failures++;
            $display("FAIL fin_ignores got en=%b stall=%b exp en=0 stall=1", s_sram_en, s_stall);
        end
        tick();
        s_write = 1'b0;
        checks++;
        if (s_n_writeback !== 32'(SDEPTH) || s_dump_done !== 1'b1) begin
            failures++;
            $display("FAIL fin_sticky got nwb=%0d done=%b exp nwb=%0d done=1", s_n_writeback, s_dump_done, SDEPTH);
        end
    endtask

    task automatic test_rst_mid_dump();
        logic [DW-1:0] d;
        logic st0, st1, found;
        s_rst = 1'b1; tick(); s_rst = 1'b0;
        s_done = 1'b1; tick(); s_done = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s_dump_ready = !(s_dump_valid && s_dump_addr == AW'(2));
            if (s_dump_valid && s_dump_addr == AW'(2)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL rst_dump_reach got found=%b exp found=1", found);
        end
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        s_dump_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_stall, s_sram_en, s_sram_we, s_dump_valid, s_dump_done, s_err} !== 6'b0 ||
            s_dump_data !== '0 || s_dump_addr !== '0 || s_data_in !== '0 || s_n_writeback !== 32'd0) begin
            failures++;
            $display("FAIL rst_dump_values got flags=%b data=%h addr=%0d nwb=%0d exp all zero",
                     {s_stall, s_sram_en, s_sram_we, s_dump_valid, s_dump_done, s_err}, s_dump_data, s_dump_addr, s_n_writeback);
        end
        tick();
        s_do_read(3, d, st0, st1);
        checks++;
        if (st0 !== 1'b1 || st1 !== 1'b0 || d !== s_ref[3]) begin
            failures++;
            $display("FAIL rst_dump_read got data=%h stall=%b%b exp data=%h stall=10", d, st0, st1, s_ref[3]);
        end
        $display("rst_mid_dump: read addr 3 after reset data=%h", d);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            mem[a]     = {$urandom, $urandom};
            ref_mem[a] = mem[a];
        end
        mem[DEPTH - 1]     = {$urandom, $urandom};
        ref_mem[DEPTH - 1] = mem[DEPTH - 1];
        test_reset();
        test_write_read();
        test_back_to_back();
        test_random();
        test_out_of_range();
        test_read_write_both();
        test_dump();
        test_rst_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/map_mem_responder.md
# map_mem_responder

Memory-side responder for the SOFM map-weight port. It accepts the level-sensitive read/write strobes that inoutcontrol drives on its 64-bit map interface and converts them into accesses to a synchronous single-port SRAM with 1-cycle read latency. It throttles the initiator with `stall`, counts writebacks, and flags bad requests. When the initiator raises `done`, it streams the whole map out over a valid/ready dump port.

## Interface
- `DEPTH`, 88594, number of 64-bit map words
- `AW`, 20, address width
- `DW`, 64, data width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `read`  in  1  read request from initiator; level, held until served
- `write`  in  1  write request from initiator; level
- `addr`  in  AW  request word address
- `data_out`  in  DW  write data from initiator
- `data_in`  out  DW  read data to initiator
- `stall`  out  1  initiator must hold `read`/`addr` while high
- `done`  in  1  initiator finished; starts the dump
- `sram_en`, `sram_we`  out  1  SRAM enable and write enable
- `sram_addr`  out  AW  SRAM address
- `sram_wdata`  out  DW  SRAM write data
- `sram_rdata`  in  DW  SRAM read data, valid one cycle after an enabled read
- `dump_valid`  out  1  dump word available
- `dump_ready`  in  1  dump consumer accepts
- `dump_addr`  out  AW  address of the dumped word
- `dump_data`  out  DW  dumped word
- `dump_done`  out  1  all DEPTH words dumped; sticky
- `n_writeback`  out  32  accepted in-range writes; wraps
- `err`  out  1  sticky; set on out-of-range access or simultaneous read+write

## Operation
- States: IDLE, RD, DUMP_RD, DUMP_OUT, FIN.
- **IDLE, read=1:** `sram_en=1`, `sram_we=0`, `sram_addr=addr`, `stall=1`, next state RD.
- **IDLE, read=1 with write=1:** read wins, write dropped, `err` set.
- **IDLE, write=1 and read=0:**
  - `sram_en=1`, `sram_we=1`, `sram_wdata=data_out`, `stall=0`, stays in IDLE.
  - `n_writeback` increments at the edge.
  - Back-to-back writes take 1 per cycle.
- **RD:**
  - `data_in` is driven combinationally from `sram_rdata`, `stall=0`.
  - `sram_rdata` is also captured into a hold register.
  - Next state IDLE.
- **Outside RD:** `data_in` shows the hold register, i.e. the last read data, or 0 after reset.
- **Out of range (addr ≥ DEPTH):** no SRAM access, `err` set.
  - A read still takes IDLE→RD and returns 0.
  - A write is dropped and not counted.
- **IDLE, done=1:** has priority over a pending read/write. Dump counter reset to 0, next state DUMP_RD.
- **DUMP_RD:** SRAM read at the dump counter, `stall=1`, next state DUMP_OUT.
- **DUMP_OUT:**
  - `dump_valid=1`, `dump_data` registered from `sram_rdata`, `dump_addr` = counter.
  - `dump_data` and `dump_addr` stay stable while `dump_ready=0`.
  - On `dump_ready=1`: if counter = DEPTH−1, go to FIN; otherwise increment the counter and go to DUMP_RD.
- **FIN:** `dump_done=1`, `stall=1`, all requests ignored; leaves only on `rst`.
- `done` is sampled only in IDLE. A `done` arriving during RD is served after RD completes.

## Timing
- **Reset values:** state IDLE; `data_in=0`, `stall=0`, `sram_en=0`, `sram_we=0`, `sram_addr=0`, `sram_wdata=0`, `dump_valid=0`, `dump_addr=0`, `dump_data=0`, `dump_done=0`, `n_writeback=0`, `err=0`.
- `rst` asserted in any state, including mid-dump, aborts the operation and returns all of the above to reset values on the next edge. No partial SRAM write is issued in that cycle.
- **Read latency:** request seen in cycle T (`stall=1`), data valid in T+1 (`stall=0`). The initiator samples `data_in` at the end of T+1. One read per 2 cycles.
- **Write latency:** 0 stall; the SRAM write happens at the end of the request cycle.
- **Read-after-write** to the same address in consecutive cycles returns the new data (SRAM write completes before the read edge).
- **Dump throughput:** 2 cycles per word with `dump_ready` held high. A full map takes 2·DEPTH cycles, then FIN.
- `stall` is combinational from state and `read`. `dump_valid` and `dump_done` are registered.

## Test plan
- Write 0x0123456789ABCDEF to addr 5, then read addr 5 → 1 cycle with `stall=0` for the write. Read shows `stall=1` then 0, `data_in`=0x0123456789ABCDEF, `n_writeback`=1.
- 4 back-to-back reads of addrs 0–3 with `read` held → `stall` toggles 1,0,1,0,…; 8 cycles total; each data matches the preloaded SRAM.
- Read addr 88594 and write addr 100000 → read returns 0, write not counted, `err`=1 and stays 1, SRAM `sram_en` never asserted.
- `read=write=1` at addr 7 → read served, SRAM addr 7 unchanged, `err`=1, `n_writeback` unchanged.
- `done` with DEPTH=4 and `dump_ready` low for 3 cycles on word 1 → words 0–3 emitted in order, word 1 held stable while stalled, then `dump_done`=1.
- `rst` pulsed during DUMP_OUT of word 2 → all outputs return to reset values next cycle. A new read then works normally.
